pmci_spi_seq: RTL and testbench

- Sequencer that turns single-word flash read/write requests into the PMCI SPI bridge register protocol over an Avalon-MM host port.
- Register set used: SPI_CSR, SPI_AR, SPI_RD_DR, SPI_WR_DR, at PMCI_DFH + 0x400..0x40C.
- Sits between firmware-facing logic (e.g. PXE/OROM fetch, FBM loader) and the PMCI CSR window.
- Serializes one request at a time, polls for completion, returns data or a timeout error.

---
 rtl/pmci_spi_seq_pkg.sv | 33 +++
 rtl/pmci_spi_poll_timer.sv | 45 ++++
 rtl/pmci_spi_seq.sv | 209 ++++++++++++++++++++
 tb/tb_pmci_spi_seq.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmci_spi_seq_pkg.sv
// Shared constants and types for the PMCI SPI bridge sequencer:
// register offsets, command codes, CSR status bits and the FSM state type.
package pmci_spi_seq_pkg;

    localparam logic [3:0] OFF_CSR   = 4'h0;
    localparam logic [3:0] OFF_AR    = 4'h4;
    localparam logic [3:0] OFF_RD_DR = 4'h8;
    localparam logic [3:0] OFF_WR_DR = 4'hC;

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    localparam int CSR_BUSY_BIT = 2;
    localparam int CSR_ERR_BIT  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_ADDR,
        ST_WR_CMD,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_GAP,
        ST_RD_DATA,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] off);
        return base + {28'd0, off};
    endfunction

endpackage

// File: rtl/pmci_spi_poll_timer.sv
// Poll bookkeeping for the SPI sequencer: saturating count of issued CSR
// reads and the idle-gap counter that spaces consecutive polls.
module pmci_spi_poll_timer #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic poll_inc,
    input  logic in_gap,
    output logic gap_done,
    output logic poll_exhausted
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;

    assign poll_exhausted = (poll_cnt == PW'(POLL_MAX));
    // With no gap configured the sequencer never enters GAP, so done is moot.
    assign gap_done = (POLL_GAP == 0) ? 1'b1 : (gap_cnt == GW'(POLL_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (clear) begin
                poll_cnt <= '0;
            end else if (poll_inc && !poll_exhausted) begin
                poll_cnt <= poll_cnt + PW'(1);
            end

            if (!in_gap) begin
                gap_cnt <= '0;
            end else if (!gap_done) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

endmodule

// File: rtl/pmci_spi_seq.sv
// Turns single-word flash read/write requests into PMCI SPI bridge register accesses.
// Define PMCI_SPI_SEQ_STATS_EN to add read/write/error statistics outputs.
module pmci_spi_seq
    import pmci_spi_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h20400,
    parameter int          AVMM_AW   = 32,
    parameter int          POLL_MAX  = 1024,
    parameter int          POLL_GAP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [AVMM_AW-1:0] avmm_address,
    output logic               avmm_write,
    output logic               avmm_read,
    output logic [31:0]        avmm_writedata,
    input  logic [31:0]        avmm_readdata,
    input  logic               avmm_readdatavalid,
    input  logic               avmm_waitrequest,
    input  logic [1:0]         avmm_response
`ifdef PMCI_SPI_SEQ_STATS_EN
    ,
    output logic [15:0]        stat_rd_cnt,
    output logic [15:0]        stat_wr_cnt,
    output logic [15:0]        stat_to_cnt
`endif
);

    localparam logic [AVMM_AW-1:0] A_CSR   = AVMM_AW'(reg_addr(BASE_ADDR, OFF_CSR));
    localparam logic [AVMM_AW-1:0] A_AR    = AVMM_AW'(reg_addr(BASE_ADDR, OFF_AR));
    localparam logic [AVMM_AW-1:0] A_RD_DR = AVMM_AW'(reg_addr(BASE_ADDR, OFF_RD_DR));
    localparam logic [AVMM_AW-1:0] A_WR_DR = AVMM_AW'(reg_addr(BASE_ADDR, OFF_WR_DR));

    state_t      state;
    logic        is_wr;
    logic [31:0] addr_q;
    logic        gap_done;
    logic        poll_exhausted;
    logic        accept;
    logic        cmd_done;

    assign accept   = (state == ST_IDLE) && req_valid;
    assign cmd_done = !avmm_waitrequest;

    pmci_spi_poll_timer #(
        .POLL_MAX (POLL_MAX),
        .POLL_GAP (POLL_GAP)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (accept),
        .poll_inc       ((state == ST_POLL_RD) && cmd_done),
        .in_gap         (state == ST_GAP),
        .gap_done       (gap_done),
        .poll_exhausted (poll_exhausted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            is_wr          <= 1'b0;
            addr_q         <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            avmm_address   <= '0;
            avmm_write     <= 1'b0;
            avmm_read      <= 1'b0;
            avmm_writedata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        is_wr      <= req_wr;
                        addr_q     <= req_addr;
                        avmm_write <= 1'b1;
                        if (req_wr) begin
                            state          <= ST_WR_DATA;
                            avmm_address   <= A_WR_DR;
                            avmm_writedata <= req_wdata;
                        end else begin
                            state          <= ST_WR_ADDR;
                            avmm_address   <= A_AR;
                            avmm_writedata <= req_addr;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (cmd_done) begin
                        state          <= ST_WR_ADDR;
                        avmm_address   <= A_AR;
                        avmm_writedata <= addr_q;
                    end
                end
                ST_WR_ADDR: begin
                    if (cmd_done) begin
                        state          <= ST_WR_CMD;
                        avmm_address   <= A_CSR;
                        avmm_writedata <= {30'd0, is_wr ? CMD_WR : CMD_RD};
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_done) begin
                        state          <= ST_POLL_RD;
                        avmm_write     <= 1'b0;
                        avmm_writedata <= '0;
                        avmm_read      <= 1'b1;
                        avmm_address   <= A_CSR;
                    end
                end
                ST_POLL_RD: begin
                    if (cmd_done) begin
                        state     <= ST_POLL_WAIT;
                        avmm_read <= 1'b0;
                    end
                end
                ST_POLL_WAIT: begin
                    if (avmm_readdatavalid) begin
                        if ((avmm_response != 2'b00) || avmm_readdata[CSR_ERR_BIT]) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!avmm_readdata[CSR_BUSY_BIT]) begin
                            if (is_wr) begin
                                state     <= ST_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_rdata <= '0;
                            end else begin
                                state        <= ST_RD_DATA;
                                avmm_read    <= 1'b1;
                                avmm_address <= A_RD_DR;
                            end
                        end else if (poll_exhausted) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (POLL_GAP == 0) begin
                            state     <= ST_POLL_RD;
                            avmm_read <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state     <= ST_POLL_RD;
                        avmm_read <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (cmd_done) begin
                        state     <= ST_RD_WAIT;
                        avmm_read <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (avmm_readdatavalid) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= (avmm_response != 2'b00);
                        rsp_rdata <= (avmm_response != 2'b00) ? 32'd0 : avmm_readdata;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef PMCI_SPI_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt <= '0;
            stat_wr_cnt <= '0;
            stat_to_cnt <= '0;
        end else if (rsp_valid) begin
            if (rsp_err) begin
                stat_to_cnt <= stat_to_cnt + 16'd1;
            end else if (is_wr) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end else begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmci_spi_seq.sv
// Directed bench for pmci_spi_seq: an Avalon-MM responder models the SPI bridge
// registers and logs every completed command; the main sequence checks the log.
module tb_pmci_spi_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] avmm_address;
    logic        avmm_write;
    logic        avmm_read;
    logic [31:0] avmm_writedata;
    logic [31:0] avmm_readdata;
    logic        avmm_readdatavalid;
    logic        avmm_waitrequest;
    logic [1:0]  avmm_response;
`ifdef PMCI_SPI_SEQ_STATS_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_to_cnt;
`endif

    pmci_spi_seq #(
        .BASE_ADDR (32'h20400),
        .AVMM_AW   (32),
        .POLL_MAX  (8),
        .POLL_GAP  (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_wr             (req_wr),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .avmm_address       (avmm_address),
        .avmm_write         (avmm_write),
        .avmm_read          (avmm_read),
        .avmm_writedata     (avmm_writedata),
        .avmm_readdata      (avmm_readdata),
        .avmm_readdatavalid (avmm_readdatavalid),
        .avmm_waitrequest   (avmm_waitrequest),
        .avmm_response      (avmm_response)
`ifdef PMCI_SPI_SEQ_STATS_EN
        ,
        .stat_rd_cnt        (stat_rd_cnt),
        .stat_wr_cnt        (stat_wr_cnt),
        .stat_to_cnt        (stat_to_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Responder configuration, written only by the main sequence.
    int          stall_cfg = 0;
    int          busy_cfg  = 0;
    logic [31:0] rd_value  = 32'h0;
    logic [1:0]  rd_resp   = 2'b00;
    int          csr_base  = 0;

    // Responder state and command log.
    logic [64:0] log_ent[$];
    int          log_cyc[$];
    int          csr_reads   = 0;
    int          stall_cnt   = 0;
    int          stall_total = 0;
    int          unstable    = 0;
    logic        pend        = 1'b0;
    logic [31:0] pend_data   = 32'h0;
    logic [1:0]  pend_resp   = 2'b00;
    logic [65:0] snap        = '0;

    initial begin
        avmm_readdata      = 32'h0;
        avmm_readdatavalid = 1'b0;
        avmm_waitrequest   = 1'b0;
        avmm_response      = 2'b00;
    end

    always @(negedge clk) begin
        avmm_readdatavalid = 1'b0;
        avmm_readdata      = 32'h0;
        avmm_response      = 2'b00;
        if (!rst_n) begin
            pend             = 1'b0;
            stall_cnt        = 0;
            avmm_waitrequest = 1'b0;
        end else begin
            if (pend) begin
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = pend_data;
                avmm_response      = pend_resp;
                pend               = 1'b0;
            end
            if (avmm_read || avmm_write) begin
                if (stall_cnt == 0)
                    snap = {avmm_read, avmm_write, avmm_address, avmm_writedata};
                else if (snap !== {avmm_read, avmm_write, avmm_address, avmm_writedata})
                    unstable++;
                if (stall_cnt < stall_cfg) begin
                    avmm_waitrequest = 1'b1;
                    stall_cnt++;
                    stall_total++;
                end else begin
                    avmm_waitrequest = 1'b0;
                    stall_cnt        = 0;
                    if (avmm_write) begin
                        log_ent.push_back({1'b1, avmm_address, avmm_writedata});
                    end else begin
                        if (avmm_address == 32'h20400) begin
                            pend_data = ((csr_reads - csr_base) < busy_cfg) ? 32'h4 : 32'h0;
                            pend_resp = 2'b00;
                            csr_reads++;
                        end else if (avmm_address == 32'h20408) begin
                            pend_data = rd_value;
                            pend_resp = rd_resp;
                        end else begin
                            pend_data = 32'hDEAD_DEAD;
                            pend_resp = 2'b11;
                        end
                        pend = 1'b1;
                        log_ent.push_back({1'b0, avmm_address, pend_data});
                    end
                    log_cyc.push_back(cyc);
                end
            end else begin
                avmm_waitrequest = 1'b0;
            end
        end
    end

    logic [64:0] expq[$];
    int          log_base;
    int          acc_cyc;
    int          rsp_cyc;
    logic [31:0] rsp_data;
    logic        rsp_e;

    function automatic logic [64:0] ent(input logic wr, input logic [31:0] a, input logic [31:0] d);
        return {wr, a, d};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_cmd_count"}, 96'(log_ent.size() - log_base), 96'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (log_base + i < log_ent.size())
                chk($sformatf("%s_cmd%0d", tag, i), 96'(log_ent[log_base + i]), 96'(expq[i]));
        end
    endtask

    task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        chk("req_ready_idle", 96'(req_ready), 96'(1));
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        log_base  = log_ent.size();
        csr_base  = csr_reads;
        acc_cyc   = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            if (rsp_valid) begin
                got      = 1'b1;
                rsp_cyc  = cyc;
                rsp_data = rsp_rdata;
                rsp_e    = rsp_err;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, "_rsp_seen"}, 96'(got), 96'(1));
        $display("txn %s: err=%0d rdata=%08h cmds=%0d", tag, rsp_e, rsp_data, log_ent.size() - log_base);
    endtask

    initial begin
        int n_csr;
        int seen;
        int stall_base;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 96'(req_ready), 96'(1));
        chk("reset_rsp", 96'({rsp_valid, rsp_err, rsp_rdata}), 96'(0));
        chk("reset_bus", 96'({avmm_read, avmm_write, avmm_address, avmm_writedata}), 96'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Flash write, no stalls, bridge idle on first poll.
        start_req(1'b1, 32'h100, 32'hDEADBEEF);
        wait_rsp("write");
        expq = '{ent(1'b1, 32'h2040C, 32'hDEADBEEF), ent(1'b1, 32'h20404, 32'h100),
                 ent(1'b1, 32'h20400, 32'h2), ent(1'b0, 32'h20400, 32'h0)};
        check_log("write");
        chk("write_err", 96'(rsp_e), 96'(0));
        chk("write_rdata", 96'(rsp_data), 96'(0));
        // Accept cycle through response cycle, inclusive.
        chk("write_latency", 96'(rsp_cyc - acc_cyc + 1), 96'(7));

        // Flash read, busy for three polls.
        busy_cfg = 3;
        rd_value = 32'h12345678;
        start_req(1'b0, 32'h200, 32'h0);
        wait_rsp("read_busy");
        expq = '{ent(1'b1, 32'h20404, 32'h200), ent(1'b1, 32'h20400, 32'h1),
                 ent(1'b0, 32'h20400, 32'h4), ent(1'b0, 32'h20400, 32'h4),
                 ent(1'b0, 32'h20400, 32'h4), ent(1'b0, 32'h20400, 32'h0),
                 ent(1'b0, 32'h20408, 32'h12345678)};
        check_log("read_busy");
        for (int k = 0; k < 3; k++) begin
            if (log_base + 3 + k < log_cyc.size())
                chk($sformatf("poll_spacing%0d", k),
                    96'(log_cyc[log_base + 3 + k] - log_cyc[log_base + 2 + k]), 96'(6));
        end
        chk("read_busy_rdata", 96'(rsp_data), 96'(32'h12345678));
        chk("read_busy_err", 96'(rsp_e), 96'(0));

        // Bridge never leaves busy: exactly POLL_MAX polls, then timeout.
        busy_cfg = 1000;
        start_req(1'b0, 32'h300, 32'h0);
        wait_rsp("timeout");
        n_csr = 0;
        for (int i = log_base; i < log_ent.size(); i++)
            if (log_ent[i][64] == 1'b0 && log_ent[i][63:32] == 32'h20400) n_csr++;
        chk("timeout_polls", 96'(n_csr), 96'(8));
        chk("timeout_cmd_count", 96'(log_ent.size() - log_base), 96'(10));
        chk("timeout_err", 96'(rsp_e), 96'(1));
        chk("timeout_rdata", 96'(rsp_data), 96'(0));
        @(negedge clk);
        chk("timeout_ready_next", 96'({req_ready, rsp_valid}), 96'(2'b10));

        // Five wait-states on every command.
        busy_cfg   = 0;
        stall_cfg  = 5;
        stall_base = stall_total;
        start_req(1'b1, 32'h40, 32'hA5A50F0F);
        wait_rsp("stall_write");
        expq = '{ent(1'b1, 32'h2040C, 32'hA5A50F0F), ent(1'b1, 32'h20404, 32'h40),
                 ent(1'b1, 32'h20400, 32'h2), ent(1'b0, 32'h20400, 32'h0)};
        check_log("stall_write");
        chk("stall_write_err", 96'(rsp_e), 96'(0));
        rd_value = 32'hCAFEF00D;
        start_req(1'b0, 32'h80, 32'h0);
        wait_rsp("stall_read");
        expq = '{ent(1'b1, 32'h20404, 32'h80), ent(1'b1, 32'h20400, 32'h1),
                 ent(1'b0, 32'h20400, 32'h0), ent(1'b0, 32'h20408, 32'hCAFEF00D)};
        check_log("stall_read");
        chk("stall_read_rdata", 96'(rsp_data), 96'(32'hCAFEF00D));
        chk("stall_cycles", 96'(stall_total - stall_base), 96'(40));
        chk("stall_stable", 96'(unstable), 96'(0));
        stall_cfg = 0;

        // Bus error on the data read.
        rd_value = 32'h11112222;
        rd_resp  = 2'b10;
        start_req(1'b0, 32'h500, 32'h0);
        wait_rsp("rd_slverr");
        chk("rd_slverr_err", 96'(rsp_e), 96'(1));
        chk("rd_slverr_rdata", 96'(rsp_data), 96'(0));
        rd_resp = 2'b00;

        // Reset while waiting between polls.
        busy_cfg = 1000;
        start_req(1'b0, 32'h600, 32'h0);
        for (int i = 0; i < 60 && (log_ent.size() - log_base) < 3; i++) @(negedge clk);
        chk("rst_first_poll", 96'(log_ent.size() - log_base), 96'(3));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_strobes", 96'({avmm_read, avmm_write}), 96'(0));
        chk("rst_req_ready", 96'(req_ready), 96'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", 96'(seen), 96'(0));
`ifdef PMCI_SPI_SEQ_STATS_EN
        chk("stat_rd_after_rst", 96'(stat_rd_cnt), 96'(0));
`endif
        busy_cfg = 0;
        rd_value = 32'h0BADF00D;
        start_req(1'b0, 32'h700, 32'h0);
        wait_rsp("post_rst_read");
        chk("post_rst_rdata", 96'(rsp_data), 96'(32'h0BADF00D));
        chk("post_rst_err", 96'(rsp_e), 96'(0));
`ifdef PMCI_SPI_SEQ_STATS_EN
        @(negedge clk);
        chk("stat_rd_after_read", 96'(stat_rd_cnt), 96'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
